// File: rtl/control_mc.sv
`default_nettype none
//==============================================================================
// Module   : control_mc
// Brief    : Multi-cycle RV32I control unit; FETCH/EXEC/MEM_WAIT/HALT sequencing
//            of one latched instruction with branch, load/store and fault handling.
// Revision : 1.0 - initial release
//==============================================================================
module control_mc #(
  parameter int HAS_BRANCH  = 1,
  parameter int HAS_MEM     = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instr_i,
  input  logic             instr_valid_i,
  input  logic [31:0]      alu_res_i,
  input  logic             mem_ready_i,
  output logic             reg_wr_en_o,
  output logic [4:0]       rd_idx_o,
  output logic [4:0]       rs1_idx_o,
  output logic [4:0]       rs2_idx_o,
  output logic [31:0]      imm_data_o,
  output logic [3:0]       alu_op_o,
  output logic             alu_a_sel_o,
  output logic             alu_b_sel_o,
  output logic             rd_sel_o,
  output logic [31:0]      pc_next_off_o,
  output logic [1:0]       pc_next_sel_o,
  output logic             mem_rd_en_o,
  output logic             mem_wr_en_o,
  output logic             mem_r_sext_o,
  output logic [1:0]       mem_acc_o,
  output logic             illegal_o,
  output logic             fault_o,
  output logic             halted_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_SLL = 4'd2;
  localparam logic [3:0] ALU_OP_LT  = 4'd3;
  localparam logic [3:0] ALU_OP_LTU = 4'd4;
  localparam logic [3:0] ALU_OP_XOR = 4'd5;
  localparam logic [3:0] ALU_OP_SRL = 4'd6;
  localparam logic [3:0] ALU_OP_SRA = 4'd7;
  localparam logic [3:0] ALU_OP_OR  = 4'd8;
  localparam logic [3:0] ALU_OP_AND = 4'd9;
  localparam logic       ALU_A_SEL_RS1 = 1'b0;
  localparam logic       ALU_A_SEL_PC  = 1'b1;
  localparam logic       ALU_B_SEL_RS2 = 1'b0;
  localparam logic       ALU_B_SEL_IMM = 1'b1;
  localparam logic       RD_SEL_ALU = 1'b0;
  localparam logic       RD_SEL_MEM = 1'b1;
  localparam logic [1:0] PC_NEXT_SEL_STALL   = 2'd0;
  localparam logic [1:0] PC_NEXT_SEL_PC_IMM  = 2'd1;
  localparam logic [1:0] PC_NEXT_SEL_RS1_IMM = 2'd2;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;

  // Wait counter only needs to reach MEM_TIMEOUT-1; it free-wraps when timeout is disabled.
  localparam int c_WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_RESET, S_FETCH, S_EXEC, S_MEM_WAIT, S_HALT} state_t;

  state_t              r_state, w_state_nxt;
  logic [31:0]         r_instr;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]    r_retire_cnt;
  logic                r_illegal, r_fault;

  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_legal, w_is_mem, w_is_load, w_taken, w_timeout_hit;

  assign w_opc   = r_instr[6:0];
  assign w_f3    = r_instr[14:12];
  assign w_f7    = r_instr[31:25];
  assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_s = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
  assign w_imm_u = {r_instr[31:12], 12'b0};
  assign w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
  assign w_taken = (w_f3[2:1] == 2'b00) ? ((alu_res_i == 32'd0) ^ w_f3[0]) : (alu_res_i[0] ^ w_f3[0]);
  assign w_timeout_hit = (MEM_TIMEOUT != 0) && (r_wait_cnt == c_WAIT_LAST);

  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? ALU_OP_SUB : ALU_OP_ADD;
      3'b001:  alu_fn = ALU_OP_SLL;
      3'b010:  alu_fn = ALU_OP_LT;
      3'b011:  alu_fn = ALU_OP_LTU;
      3'b100:  alu_fn = ALU_OP_XOR;
      3'b101:  alu_fn = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'b110:  alu_fn = ALU_OP_OR;
      default: alu_fn = ALU_OP_AND;
    endcase
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    reg_wr_en_o   = 1'b0;
    rd_idx_o      = 5'd0;
    rs1_idx_o     = 5'd0;
    rs2_idx_o     = 5'd0;
    imm_data_o    = 32'd0;
    alu_op_o      = ALU_OP_ADD;
    alu_a_sel_o   = ALU_A_SEL_RS1;
    alu_b_sel_o   = ALU_B_SEL_RS2;
    rd_sel_o      = RD_SEL_ALU;
    pc_next_off_o = 32'd4;
    pc_next_sel_o = PC_NEXT_SEL_STALL;
    mem_rd_en_o   = 1'b0;
    mem_wr_en_o   = 1'b0;
    mem_r_sext_o  = 1'b0;
    mem_acc_o     = 2'b00;
    retire_o      = 1'b0;
    w_legal       = 1'b0;
    w_is_mem      = 1'b0;
    w_is_load     = 1'b0;

    // Decode is live in EXEC and kept stable through MEM_WAIT so the address path holds.
    if (r_state == S_EXEC || r_state == S_MEM_WAIT) begin
      rd_idx_o  = r_instr[11:7];
      rs1_idx_o = r_instr[19:15];
      rs2_idx_o = r_instr[24:20];
      case (w_opc)
        c_OPC_OP: begin
          w_legal = (w_f7 == 7'b0000000) ||
                    (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101));
          alu_op_o = alu_fn(w_f3, w_f7[5]);
          reg_wr_en_o = 1'b1; pc_next_sel_o = PC_NEXT_SEL_PC_IMM; retire_o = 1'b1;
        end
        c_OPC_OPIMM: begin
          w_legal = (w_f3 == 3'b001) ? (w_f7 == 7'b0000000) :
                    (w_f3 == 3'b101) ? (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) : 1'b1;
          alu_op_o = alu_fn(w_f3, (w_f3 == 3'b101) && w_f7[5]);
          alu_b_sel_o = ALU_B_SEL_IMM; imm_data_o = w_imm_i;
          reg_wr_en_o = 1'b1; pc_next_sel_o = PC_NEXT_SEL_PC_IMM; retire_o = 1'b1;
        end
        c_OPC_LUI, c_OPC_AUIPC: begin
          w_legal = 1'b1;
          rs1_idx_o = 5'd0;
          alu_a_sel_o = (w_opc == c_OPC_AUIPC) ? ALU_A_SEL_PC : ALU_A_SEL_RS1;
          alu_b_sel_o = ALU_B_SEL_IMM; imm_data_o = w_imm_u;
          reg_wr_en_o = 1'b1; pc_next_sel_o = PC_NEXT_SEL_PC_IMM; retire_o = 1'b1;
        end
        c_OPC_JAL, c_OPC_JALR: begin
          w_legal = (w_opc == c_OPC_JAL) || (w_f3 == 3'b000);
          alu_a_sel_o = ALU_A_SEL_PC; alu_b_sel_o = ALU_B_SEL_IMM; imm_data_o = 32'd4;
          pc_next_off_o = (w_opc == c_OPC_JAL) ? w_imm_j : w_imm_i;
          pc_next_sel_o = (w_opc == c_OPC_JAL) ? PC_NEXT_SEL_PC_IMM : PC_NEXT_SEL_RS1_IMM;
          reg_wr_en_o = 1'b1; retire_o = 1'b1;
        end
        c_OPC_BRANCH: begin
          w_legal = (HAS_BRANCH != 0) && (w_f3[2:1] != 2'b01);
          alu_op_o = (w_f3[2:1] == 2'b00) ? ALU_OP_SUB : (w_f3[1] ? ALU_OP_LTU : ALU_OP_LT);
          pc_next_off_o = w_taken ? w_imm_b : 32'd4;
          pc_next_sel_o = PC_NEXT_SEL_PC_IMM; retire_o = 1'b1;
        end
        c_OPC_LOAD, c_OPC_STORE: begin
          w_is_load = (w_opc == c_OPC_LOAD);
          w_is_mem  = 1'b1;
          w_legal = (HAS_MEM != 0) && (w_f3[1:0] != 2'b11) &&
                    (w_is_load ? (w_f3 != 3'b110) : !w_f3[2]);
          alu_b_sel_o = ALU_B_SEL_IMM;
          imm_data_o  = w_is_load ? w_imm_i : w_imm_s;
          mem_rd_en_o = w_is_load; mem_wr_en_o = !w_is_load;
          mem_acc_o = w_f3[1:0]; mem_r_sext_o = !w_f3[2];
        end
        default: w_legal = 1'b0;
      endcase
    end

    case (r_state)
      S_RESET: w_state_nxt = S_FETCH;
      S_FETCH: if (instr_valid_i) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (!w_legal) begin
          reg_wr_en_o = 1'b0; retire_o = 1'b0; mem_rd_en_o = 1'b0; mem_wr_en_o = 1'b0;
          pc_next_sel_o = PC_NEXT_SEL_STALL; pc_next_off_o = 32'd4;
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = w_is_mem ? S_MEM_WAIT : S_FETCH;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready_i) begin
          retire_o = 1'b1; pc_next_sel_o = PC_NEXT_SEL_PC_IMM; pc_next_off_o = 32'd4;
          if (w_is_load) begin
            reg_wr_en_o = 1'b1; rd_sel_o = RD_SEL_MEM;
          end
          w_state_nxt = S_FETCH;
        end else if (w_timeout_hit) begin
          w_state_nxt = S_HALT;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_RESET;
    endcase

    if (rd_idx_o == 5'd0) reg_wr_en_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_RESET;
      r_instr      <= 32'd0;
      r_wait_cnt   <= '0;
      r_retire_cnt <= '0;
      r_illegal    <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_FETCH && instr_valid_i) r_instr <= instr_i;
      if (r_state == S_EXEC) begin
        r_wait_cnt <= '0;
        if (!w_legal) r_illegal <= 1'b1;
      end
      if (r_state == S_MEM_WAIT && !mem_ready_i) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
        if (w_timeout_hit) r_fault <= 1'b1;
      end
      r_retire_cnt <= r_retire_cnt + CNT_W'(retire_o);
    end
  end

  assign illegal_o    = r_illegal;
  assign fault_o      = r_fault;
  assign halted_o     = (r_state == S_HALT);
  assign retire_cnt_o = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_control_mc.sv
`default_nettype none
//==============================================================================
// Module   : tb_control_mc
// Brief    : Directed self-checking bench for control_mc (default build plus a
//            HAS_MEM=0 / CNT_W=4 build driven by the same stimulus).
// Revision : 1.0 - initial release
//==============================================================================
module tb_control_mc;

  localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_BEQ_M8  = 32'hFE10_8CE3;  // beq  x1,x1,-8
  localparam logic [31:0] I_BNE_M8  = 32'hFE10_9CE3;  // bne  x1,x1,-8
  localparam logic [31:0] I_BLT_M8  = 32'hFE10_CCE3;  // blt  x1,x1,-8
  localparam logic [31:0] I_LW      = 32'h0040_A103;  // lw   x2,4(x1)
  localparam logic [31:0] I_SW      = 32'h0020_A023;  // sw   x2,0(x1)
  localparam logic [31:0] I_NOP     = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] I_BAD     = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic instr_valid = 1'b0;
  logic [31:0] alu_res = 32'd0;
  logic mem_ready = 1'b0;

  logic reg_wr_en, alu_a_sel, alu_b_sel, rd_sel, mem_rd_en, mem_wr_en, mem_r_sext;
  logic illegal, fault, halted, retire;
  logic [4:0] rd_idx, rs1_idx, rs2_idx;
  logic [31:0] imm_data, pc_next_off, retire_cnt;
  logic [3:0] alu_op;
  logic [1:0] pc_next_sel, mem_acc;

  logic nm_reg_wr_en, nm_alu_a_sel, nm_alu_b_sel, nm_rd_sel, nm_mem_rd_en, nm_mem_wr_en, nm_mem_r_sext;
  logic nm_illegal, nm_fault, nm_halted, nm_retire;
  logic [4:0] nm_rd_idx, nm_rs1_idx, nm_rs2_idx;
  logic [31:0] nm_imm_data, nm_pc_next_off;
  logic [3:0] nm_alu_op, nm_retire_cnt;
  logic [1:0] nm_pc_next_sel, nm_mem_acc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  control_mc u_dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instr_valid),
    .alu_res_i(alu_res), .mem_ready_i(mem_ready),
    .reg_wr_en_o(reg_wr_en), .rd_idx_o(rd_idx), .rs1_idx_o(rs1_idx), .rs2_idx_o(rs2_idx),
    .imm_data_o(imm_data), .alu_op_o(alu_op), .alu_a_sel_o(alu_a_sel), .alu_b_sel_o(alu_b_sel),
    .rd_sel_o(rd_sel), .pc_next_off_o(pc_next_off), .pc_next_sel_o(pc_next_sel),
    .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_r_sext_o(mem_r_sext),
    .mem_acc_o(mem_acc), .illegal_o(illegal), .fault_o(fault), .halted_o(halted),
    .retire_o(retire), .retire_cnt_o(retire_cnt)
  );

  control_mc #(.HAS_BRANCH(1), .HAS_MEM(0), .MEM_TIMEOUT(16), .CNT_W(4)) u_dut_nm (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instr_valid),
    .alu_res_i(alu_res), .mem_ready_i(mem_ready),
    .reg_wr_en_o(nm_reg_wr_en), .rd_idx_o(nm_rd_idx), .rs1_idx_o(nm_rs1_idx), .rs2_idx_o(nm_rs2_idx),
    .imm_data_o(nm_imm_data), .alu_op_o(nm_alu_op), .alu_a_sel_o(nm_alu_a_sel), .alu_b_sel_o(nm_alu_b_sel),
    .rd_sel_o(nm_rd_sel), .pc_next_off_o(nm_pc_next_off), .pc_next_sel_o(nm_pc_next_sel),
    .mem_rd_en_o(nm_mem_rd_en), .mem_wr_en_o(nm_mem_wr_en), .mem_r_sext_o(nm_mem_r_sext),
    .mem_acc_o(nm_mem_acc), .illegal_o(nm_illegal), .fault_o(nm_fault), .halted_o(nm_halted),
    .retire_o(nm_retire), .retire_cnt_o(nm_retire_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUTs in RESET with rst released; one more cyc reaches FETCH.
  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; alu_res = 32'd0;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
  endtask

  // Called in FETCH; returns settled inside EXEC of the given instruction.
  task automatic fetch(input logic [31:0] ins);
    instr = ins; instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    #1;
  endtask

  initial begin
    int n_rd, n_wr, n_mw;
    logic rd_sel_seen;

    // Reset state
    do_reset();
    check_eq("rst_halted", halted, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_mem_en", {mem_rd_en, mem_wr_en}, 0);
    check_eq("rst_pc_sel", pc_next_sel, 0);
    check_eq("rst_pc_off", pc_next_off, 32'd4);
    check_eq("rst_alu_op", alu_op, 0);
    check_eq("rst_cnt", retire_cnt, 0);

    // ADDI then taken BEQ, untaken BNE, taken BLT
    cyc();
    fetch(I_ADDI_X1);
    check_eq("addi_retire", retire, 1);
    check_eq("addi_wr", reg_wr_en, 1);
    check_eq("addi_rd", rd_idx, 1);
    check_eq("addi_imm", imm_data, 32'd5);
    check_eq("addi_pc_sel", pc_next_sel, 1);
    cyc();
    alu_res = 32'd0;
    fetch(I_BEQ_M8);
    check_eq("beq_retire", retire, 1);
    check_eq("beq_alu_op", alu_op, 4'd1);
    check_eq("beq_off", pc_next_off, 32'hFFFF_FFF8);
    check_eq("beq_wr", reg_wr_en, 0);
    cyc();
    check_eq("beq_cnt", retire_cnt, 2);
    fetch(I_BNE_M8);
    check_eq("bne_off", pc_next_off, 32'd4);
    cyc();
    alu_res = 32'd1;
    fetch(I_BLT_M8);
    check_eq("blt_alu_op", alu_op, 4'd3);
    check_eq("blt_off", pc_next_off, 32'hFFFF_FFF8);
    cyc();
    check_eq("blt_cnt", retire_cnt, 4);

    // LW with ready on the third request cycle
    do_reset();
    cyc();
    fetch(I_LW);
    check_eq("lw_acc", mem_acc, 2);
    check_eq("lw_sext", mem_r_sext, 1);
    check_eq("lw_pc_sel", pc_next_sel, 0);
    n_rd = 0; n_wr = 0; rd_sel_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (mem_rd_en) n_rd++;
      mem_ready = (n_rd == 3) && mem_rd_en;
      #1;
      if (reg_wr_en) begin
        n_wr++;
        rd_sel_seen = rd_sel;
      end
      cyc();
      mem_ready = 1'b0;
      #1;
    end
    check_eq("lw_rd_cycles", n_rd, 3);
    check_eq("lw_wr_cycles", n_wr, 1);
    check_eq("lw_rd_sel_mem", rd_sel_seen, 1);
    check_eq("lw_cnt", retire_cnt, 1);

    // SW that never completes -> timeout
    do_reset();
    cyc();
    fetch(I_SW);
    check_eq("sw_wr_en", mem_wr_en, 1);
    n_mw = 0;
    for (int k = 0; k < 40 && !halted; k++) begin
      cyc();
      if (mem_wr_en) n_mw++;
    end
    check_eq("sw_wait_cycles", n_mw, 16);
    check_eq("sw_halted", halted, 1);
    check_eq("sw_fault", fault, 1);
    check_eq("sw_illegal", illegal, 0);
    check_eq("sw_halt_en", mem_wr_en, 0);
    check_eq("sw_cnt", retire_cnt, 0);

    // Ready arriving in the timeout cycle completes the access
    do_reset();
    cyc();
    fetch(I_SW);
    repeat (16) cyc();
    mem_ready = 1'b1;
    #1;
    check_eq("edge_retire", retire, 1);
    cyc();
    mem_ready = 1'b0;
    #1;
    check_eq("edge_halted", halted, 0);
    check_eq("edge_fault", fault, 0);
    check_eq("edge_cnt", retire_cnt, 1);

    // Illegal instruction
    do_reset();
    cyc();
    fetch(I_BAD);
    check_eq("bad_wr", reg_wr_en, 0);
    check_eq("bad_retire", retire, 0);
    cyc();
    check_eq("bad_illegal", illegal, 1);
    check_eq("bad_halted", halted, 1);
    repeat (3) cyc();
    check_eq("bad_stays_halted", halted, 1);

    // Load with HAS_MEM=0 is illegal
    do_reset();
    cyc();
    fetch(I_LW);
    check_eq("nm_lw_rd_en", nm_mem_rd_en, 0);
    check_eq("nm_lw_wr", nm_reg_wr_en, 0);
    cyc();
    check_eq("nm_lw_illegal", nm_illegal, 1);
    check_eq("nm_lw_halted", nm_halted, 1);
    check_eq("main_lw_waiting", mem_rd_en, 1);

    // Reset in the middle of a load
    do_reset();
    cyc();
    fetch(I_ADDI_X1);
    cyc();
    fetch(I_LW);
    cyc();
    check_eq("mid_rd_en", mem_rd_en, 1);
    check_eq("mid_cnt", retire_cnt, 1);
    rst = 1'b1;
    mem_ready = 1'b1;
    cyc();
    check_eq("mid_rst_rd_en", mem_rd_en, 0);
    check_eq("mid_rst_wr", reg_wr_en, 0);
    check_eq("mid_rst_retire", retire, 0);
    check_eq("mid_rst_cnt", retire_cnt, 0);
    mem_ready = 1'b0;
    rst = 1'b0;

    // 16 NOPs: 4-bit counter wraps, x0 is never written
    do_reset();
    cyc();
    n_wr = 0;
    for (int k = 0; k < 16; k++) begin
      fetch(I_NOP);
      if (reg_wr_en) n_wr++;
      if (nm_reg_wr_en) n_wr++;
      cyc();
      if (k == 14) check_eq("nop_cnt4_15", nm_retire_cnt, 15);
    end
    check_eq("nop_no_wr", n_wr, 0);
    check_eq("nop_cnt4_wrap", nm_retire_cnt, 0);
    check_eq("nop_cnt32", retire_cnt, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
